// File: rtl/rf_2p_clr.sv
// rf_2p_clr: parametrised single-clock two-port register file with hardware clear sequencer
// Ports: clk; rstn (asynchronous, active low); clr_i request clear / busy_o clear running;
//        cena_i, addra_i -> dataa_o, vala_o registered read port A;
//        cenb_i, wenb_i, addrb_i, datab_i write port B (write when cenb_i and wenb_i both low).
// Optional: define RF_2P_BYPASS_EN to forward datab_i to a same-address read in the same cycle.
module rf_2p_clr #(
    parameter int Word_Width = 23,
    parameter int Addr_Width = 6,
    parameter int Depth      = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    output logic                  busy_o,
    input  logic                  cena_i,
    input  logic [Addr_Width-1:0] addra_i,
    output logic [Word_Width-1:0] dataa_o,
    output logic                  vala_o,
    input  logic                  cenb_i,
    input  logic                  wenb_i,
    input  logic [Addr_Width-1:0] addrb_i,
    input  logic [Word_Width-1:0] datab_i
);
    typedef enum logic {CLEAR, IDLE} state_e;
    // one extra counter bit so Depth == 2**Addr_Width is representable
    localparam logic [Addr_Width:0] Last = (Addr_Width + 1)'(Depth - 1);
    localparam logic [Addr_Width:0] Lim  = (Addr_Width + 1)'(Depth);
    state_e                state_q, state_d;
    logic [Addr_Width:0]   clr_cnt_q, clr_cnt_d;
    logic [Word_Width-1:0] mem_q [Depth];
    logic [Word_Width-1:0] dataa_q, dataa_d;
    logic                  vala_q;
    logic                  rd, rd_ok, wr_ok;
    assign busy_o  = state_q == CLEAR;
    assign rd      = !cena_i;
    assign rd_ok   = !busy_o && ({1'b0, addra_i} < Lim);
    assign wr_ok   = !cenb_i && !wenb_i && !busy_o && ({1'b0, addrb_i} < Lim);
    assign dataa_o = dataa_q;
    assign vala_o  = vala_q;
`ifdef RF_2P_BYPASS_EN
    assign dataa_d = !rd_ok ? '0 : (wr_ok && addrb_i == addra_i) ? datab_i : mem_q[addra_i];
`else
    assign dataa_d = rd_ok ? mem_q[addra_i] : '0;
`endif
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            state_d   = clr_cnt_q == Last ? IDLE : CLEAR;
            clr_cnt_d = clr_cnt_q == Last ? clr_cnt_q : clr_cnt_q + (Addr_Width + 1)'(1);
        end else if (clr_i) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            dataa_q   <= '0;
            vala_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            vala_q    <= rd;
            if (rd) dataa_q <= dataa_d;
        end
    end
    // the array itself is never reset; the sequencer is its only initialisation
    always_ff @(posedge clk) begin
        if (busy_o) mem_q[clr_cnt_q[Addr_Width-1:0]] <= '0;
        else if (wr_ok) mem_q[addrb_i] <= datab_i;
    end
endmodule

// File: tb/tb_rf_2p_clr.sv
// tb_rf_2p_clr: randomized self-checking bench for rf_2p_clr (Depth 64 and Depth 40 instances)
module tb_rf_2p_clr;
    localparam int W = 23;
    localparam int AW = 6;
`ifdef RF_2P_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rstn = 1'b0, clr_i = 1'b0;
    logic cena = 1'b1, cenb = 1'b1, wenb = 1'b1;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [W-1:0] datab = '0;
    logic busy0, busy1, val0, val1;
    logic [W-1:0] d0, d1;
    logic bo [2];
    logic vo [2];
    logic [W-1:0] dout [2];
    int pass = 0, total = 0;
    int dep [2] = '{64, 40};
    logic [W-1:0] m [2][64];
    int bl [2];
    logic [W-1:0] ed [2];
    logic ev [2];

    assign bo[0] = busy0;
    assign bo[1] = busy1;
    assign vo[0] = val0;
    assign vo[1] = val1;
    assign dout[0] = d0;
    assign dout[1] = d1;

    always #5 clk = ~clk;

    rf_2p_clr #(.Word_Width(W), .Addr_Width(AW), .Depth(64)) u0 (
        .clk(clk), .rstn(rstn), .clr_i(clr_i), .busy_o(busy0),
        .cena_i(cena), .addra_i(addra), .dataa_o(d0), .vala_o(val0),
        .cenb_i(cenb), .wenb_i(wenb), .addrb_i(addrb), .datab_i(datab));

    rf_2p_clr #(.Word_Width(W), .Addr_Width(AW), .Depth(40)) u1 (
        .clk(clk), .rstn(rstn), .clr_i(clr_i), .busy_o(busy1),
        .cena_i(cena), .addra_i(addra), .dataa_o(d1), .vala_o(val1),
        .cenb_i(cenb), .wenb_i(wenb), .addrb_i(addrb), .datab_i(datab));

    // reference: a busy countdown per instance; a clear wipes the whole model array at once
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            bl[k] = dep[k];
            ed[k] = '0;
            ev[k] = 1'b0;
            for (int a = 0; a < 64; a++) m[k][a] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit busy = bl[k] > 0;
            bit wr = !cenb && !wenb;
            if (!cena) begin
                ev[k] = 1'b1;
                if (busy || int'(addra) >= dep[k]) ed[k] = '0;
                else if (BYP && wr && addrb == addra) ed[k] = datab;
                else ed[k] = m[k][addra];
            end else ev[k] = 1'b0;
            if (!busy && wr && int'(addrb) < dep[k]) m[k][addrb] = datab;
            if (busy) bl[k]--;
            else if (clr_i) begin
                bl[k] = dep[k];
                for (int a = 0; a < 64; a++) m[k][a] = '0;
            end
        end
        #1;
    endtask

    task automatic idle();
        cena = 1'b1; cenb = 1'b1; wenb = 1'b1; clr_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        idle();
        while ((bo[0] || bo[1]) && n < 200) begin step(); n++; end
        total++;
        if (bo[0] || bo[1]) begin
            $display("FAIL wait_idle: busy0=%0b busy1=%0b required 0 0", bo[0], bo[1]);
        end else pass++;
    endtask

    task automatic test_reset();
        int n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total += 3;
            if (bo[k] !== 1'b1) $display("FAIL reset_busy%0d: got %0b required 1", k, bo[k]); else pass++;
            if (vo[k] !== 1'b0) $display("FAIL reset_val%0d: got %0b required 0", k, vo[k]); else pass++;
            if (dout[k] !== '0) $display("FAIL reset_data%0d: got %h required 0", k, dout[k]); else pass++;
        end
        rstn = 1'b1;
        model_reset();
        while (bo[0] && n < 200) begin
            step();
            n++;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (bo[k] !== (bl[k] > 0)) $display("FAIL reset_clear_busy%0d: got %0b required %0b at cycle %0d", k, bo[k], bl[k] > 0, n);
                else pass++;
            end
        end
        total++;
        if (n != 64) $display("FAIL reset_clear_len: got %0d cycles required 64", n); else pass++;
        for (int a = 0; a < 64; a++) begin
            cena = 1'b0; addra = AW'(a);
            step();
            total += 2;
            if (dout[0] !== '0) $display("FAIL reset_read_data a=%0d: got %h required 0", a, dout[0]); else pass++;
            if (vo[0] !== 1'b1) $display("FAIL reset_read_val a=%0d: got %0b required 1", a, vo[0]); else pass++;
        end
        idle();
    endtask

    task automatic test_write_read();
        cenb = 1'b0; wenb = 1'b0; addrb = 6'd3; datab = 23'h5A5A5;
        step();
        idle(); cena = 1'b0; addra = 6'd3;
        step();
        total += 2;
        if (dout[0] !== 23'h5A5A5) $display("FAIL wr_rd_data: got %h required 5a5a5", dout[0]); else pass++;
        if (vo[0] !== 1'b1) $display("FAIL wr_rd_val: got %0b required 1", vo[0]); else pass++;
        idle();
        step(); step();
        total += 2;
        if (dout[0] !== 23'h5A5A5) $display("FAIL hold_data: got %h required 5a5a5", dout[0]); else pass++;
        if (vo[0] !== 1'b0) $display("FAIL hold_val: got %0b required 0", vo[0]); else pass++;
    endtask

    task automatic test_collision();
        cenb = 1'b0; wenb = 1'b0; addrb = 6'd7; datab = 23'h1;
        step();
        datab = 23'h2; cena = 1'b0; addra = 6'd7;
        step();
        total += 2;
        if (dout[0] !== (BYP ? 23'h2 : 23'h1)) $display("FAIL collision: got %h required %h", dout[0], BYP ? 23'h2 : 23'h1); else pass++;
        if (dout[1] !== ed[1]) $display("FAIL collision_d40: got %h required %h", dout[1], ed[1]); else pass++;
        idle(); cena = 1'b0;
        step();
        total++;
        if (dout[0] !== 23'h2) $display("FAIL collision_next: got %h required 2", dout[0]); else pass++;
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cena = $urandom_range(0, 2) == 0;
            addra = AW'($urandom_range(0, 63));
            cenb = $urandom_range(0, 1) == 1;
            wenb = $urandom_range(0, 3) == 0;
            addrb = ($urandom_range(0, 3) == 0) ? addra : AW'($urandom_range(0, 63));
            datab = W'($urandom);
            clr_i = $urandom_range(0, 149) == 0;
            step();
            for (int k = 0; k < 2; k++) begin
                total += 3;
                if (bo[k] !== (bl[k] > 0)) $display("FAIL rand_busy%0d i=%0d: got %0b required %0b", k, i, bo[k], bl[k] > 0); else pass++;
                if (vo[k] !== ev[k]) $display("FAIL rand_val%0d i=%0d: got %0b required %0b", k, i, vo[k], ev[k]); else pass++;
                if (dout[k] !== ed[k]) $display("FAIL rand_data%0d i=%0d: got %h required %h", k, i, dout[k], ed[k]); else pass++;
            end
        end
        idle();
    endtask

    task automatic test_clear();
        int n = 0, n1 = 0;
        wait_idle();
        for (int a = 0; a < 64; a++) begin
            cenb = 1'b0; wenb = 1'b0; addrb = AW'(a); datab = 23'h7FFFFF;
            step();
        end
        idle(); clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        while (bo[0] && n < 200) begin
            if (bo[1]) n1++;
            idle();
            if (n == 10) begin
                clr_i = 1'b1; cenb = 1'b0; wenb = 1'b0; addrb = 6'd5; datab = 23'h123;
            end
            step();
            n++;
        end
        idle();
        total += 2;
        if (n != 64) $display("FAIL clear_len64: got %0d cycles required 64", n); else pass++;
        if (n1 != 40) $display("FAIL clear_len40: got %0d cycles required 40", n1); else pass++;
        total++;
        if (bo[0] !== 1'b0) $display("FAIL clear_restart: busy got %0b required 0", bo[0]); else pass++;
        for (int a = 0; a < 64; a++) begin
            cena = 1'b0; addra = AW'(a);
            step();
            total += 2;
            if (dout[0] !== '0) $display("FAIL clear_read a=%0d: got %h required 0", a, dout[0]); else pass++;
            if (dout[1] !== ed[1]) $display("FAIL clear_read40 a=%0d: got %h required %h", a, dout[1], ed[1]); else pass++;
        end
        idle();
    endtask

    task automatic test_out_of_range();
        wait_idle();
        cenb = 1'b0; wenb = 1'b0; addrb = 6'd50; datab = 23'h1234;
        step();
        idle(); cena = 1'b0; addra = 6'd50;
        step();
        total += 3;
        if (dout[1] !== '0) $display("FAIL oor_data: got %h required 0", dout[1]); else pass++;
        if (vo[1] !== 1'b1) $display("FAIL oor_val: got %0b required 1", vo[1]); else pass++;
        if (dout[0] !== 23'h1234) $display("FAIL oor_inrange64: got %h required 1234", dout[0]); else pass++;
        idle();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wait_idle();
        cenb = 1'b0; wenb = 1'b0; addrb = 6'd9; datab = 23'h55;
        step();
        idle(); cena = 1'b0; addra = 6'd9; clr_i = 1'b1;
        step();
        idle();
        for (int i = 0; i < 20; i++) step();
        total += 2;
        if (dout[0] !== 23'h55) $display("FAIL mid_hold: got %h required 55", dout[0]); else pass++;
        if (bo[0] !== 1'b1) $display("FAIL mid_busy_pre: got %0b required 1", bo[0]); else pass++;
        cena = 1'b0; addra = 6'd9;
        step();
        rstn = 1'b0;
        #1;
        total += 3;
        if (bo[0] !== 1'b1) $display("FAIL mid_busy: got %0b required 1", bo[0]); else pass++;
        if (dout[0] !== '0) $display("FAIL mid_data: got %h required 0", dout[0]); else pass++;
        if (vo[0] !== 1'b0) $display("FAIL mid_val: got %0b required 0", vo[0]); else pass++;
        idle();
        rstn = 1'b1;
        model_reset();
        while (bo[0] && n < 200) begin step(); n++; end
        total++;
        if (n != 64) $display("FAIL mid_clear_len: got %0d cycles required 64", n); else pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_collision();
        test_random();
        test_clear();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
